// File: rtl/sr_regfile_dumper_pkg.sv
// rtl/sr_regfile_dumper_pkg.sv - shared encodings for the register-file dump port
package sr_regfile_dumper_pkg;

    // Frame sequencer states
    typedef enum logic [2:0] {
        SR_DUMP_IDLE   = 3'd0,
        SR_DUMP_SETTLE = 3'd1,
        SR_DUMP_SEND   = 3'd2,
        SR_DUMP_CSUM   = 3'd3,
        SR_DUMP_DONE   = 3'd4
    } sr_dump_state_t;

    // Upper three bits of every per-register header byte
    localparam logic [2:0] SR_DUMP_HDR_TAG = 3'b101;

    function automatic logic [7:0] sr_dump_hdr(input logic [4:0] idx);
        return {SR_DUMP_HDR_TAG, idx};
    endfunction

endpackage

// File: rtl/sr_dump_serializer.sv
// rtl/sr_dump_serializer.sv - word-to-byte serializer with optional leading header byte
//
// Ports:
//   clk, rst_n          clock / async active-low reset
//   i_load              load i_word (and i_hdr if i_hdr_en); first byte valid next cycle
//   i_word, i_hdr       32-bit payload (sent LSB first) and header byte
//   i_hdr_en            1: header byte precedes the payload
//   i_tready            sink accepts the presented byte
//   o_tdata, o_tvalid   presented byte
//   o_last_accepted     high in the cycle the final byte of the load is accepted
module sr_dump_serializer
    import sr_regfile_dumper_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_load,
    input  logic [31:0] i_word,
    input  logic [7:0]  i_hdr,
    input  logic        i_hdr_en,
    input  logic        i_tready,
    output logic [7:0]  o_tdata,
    output logic        o_tvalid,
    output logic        o_last_accepted
);

    logic [31:0] r_buf;     // bytes queued behind r_tdata, next one in [7:0]
    logic [2:0]  r_left;    // number of bytes still queued in r_buf
    logic [7:0]  r_tdata;
    logic        r_tvalid;
    logic        w_accept;

    assign w_accept        = r_tvalid & i_tready;
    assign o_last_accepted = w_accept && (r_left == 3'd0);
    assign o_tdata         = r_tdata;
    assign o_tvalid        = r_tvalid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_buf    <= 32'h0;
            r_left   <= 3'd0;
            r_tdata  <= 8'h00;
            r_tvalid <= 1'b0;
        end else if (i_load) begin
            r_tvalid <= 1'b1;
            if (i_hdr_en) begin
                r_tdata <= i_hdr;
                r_buf   <= i_word;
                r_left  <= 3'd4;
            end else begin
                r_tdata <= i_word[7:0];
                r_buf   <= {8'h00, i_word[31:8]};
                r_left  <= 3'd3;
            end
        end else if (w_accept) begin
            if (r_left == 3'd0) begin
                r_tvalid <= 1'b0;
            end else begin
                // Next byte goes out on the same edge for 1 byte/cycle throughput
                r_tdata <= r_buf[7:0];
                r_buf   <= {8'h00, r_buf[31:8]};
                r_left  <= r_left - 3'd1;
            end
        end
    end

endmodule

// File: rtl/sr_regfile_dumper.sv
// rtl/sr_regfile_dumper.sv - walks CPU registers and streams them as a checksummed byte frame
//
// Ports:
//   clk, rst_n          clock / async active-low reset
//   start               level, sampled only in IDLE, begins one frame
//   busy, done          frame in progress / one-cycle completion pulse
//   regAddr, regData    CPU debug register port (regData combinational on regAddr)
//   tx_data, tx_valid   byte stream to the sink
//   tx_ready            sink accepts when high together with tx_valid
module sr_regfile_dumper
    import sr_regfile_dumper_pkg::*;
#(
    parameter int FIRST_REG     = 0,
    parameter int LAST_REG      = 31,
    parameter int SETTLE_CYCLES = 1,
    parameter int ADD_HEADER    = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic [4:0]  regAddr,
    input  logic [31:0] regData,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready
);

    localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);

    sr_dump_state_t r_state;
    logic [4:0]     r_addr;
    logic [7:0]     r_csum;
    logic [7:0]     r_settle_cnt;
    logic           r_busy;
    logic           r_done;

    logic           w_load;
    logic [7:0]     w_ser_tdata;
    logic           w_ser_tvalid;
    logic           w_last_acc;
    logic [7:0]     w_csum_acc;

    // Snapshot is taken on the final settle edge
    assign w_load     = (r_state == SR_DUMP_SETTLE) && (r_settle_cnt == SETTLE_LAST);
    assign w_csum_acc = r_csum + tx_data;

    // The checksum byte is presented straight from r_csum; everything else comes
    // from the serializer
    assign tx_valid = (r_state == SR_DUMP_CSUM) | w_ser_tvalid;
    assign tx_data  = (r_state == SR_DUMP_CSUM) ? r_csum : w_ser_tdata;
    assign regAddr  = r_addr;
    assign busy     = r_busy;
    assign done     = r_done;

    sr_dump_serializer u_ser (
        .clk             (clk),
        .rst_n           (rst_n),
        .i_load          (w_load),
        .i_word          (regData),
        .i_hdr           (sr_dump_hdr(r_addr)),
        .i_hdr_en        (ADD_HEADER != 0),
        .i_tready        (tx_ready),
        .o_tdata         (w_ser_tdata),
        .o_tvalid        (w_ser_tvalid),
        .o_last_accepted (w_last_acc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= SR_DUMP_IDLE;
            r_addr       <= 5'(FIRST_REG);
            r_csum       <= 8'h00;
            r_settle_cnt <= 8'h00;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            case (r_state)
                SR_DUMP_IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_busy       <= 1'b1;
                        r_addr       <= 5'(FIRST_REG);
                        r_settle_cnt <= 8'h00;
                        r_csum       <= 8'h00;
                        r_state      <= SR_DUMP_SETTLE;
                    end
                end
                SR_DUMP_SETTLE: begin
                    if (w_load) begin
                        r_settle_cnt <= 8'h00;
                        r_state      <= SR_DUMP_SEND;
                    end else begin
                        r_settle_cnt <= r_settle_cnt + 8'h01;
                    end
                end
                SR_DUMP_SEND: begin
                    if (tx_valid && tx_ready) begin
                        r_csum <= w_csum_acc;
                    end
                    if (w_last_acc) begin
                        if (r_addr == 5'(LAST_REG)) begin
                            r_state <= SR_DUMP_CSUM;
                        end else begin
                            r_addr  <= r_addr + 5'd1;
                            r_state <= SR_DUMP_SETTLE;
                        end
                    end
                end
                SR_DUMP_CSUM: begin
                    if (tx_ready) begin
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= SR_DUMP_DONE;
                    end
                end
                SR_DUMP_DONE: begin
                    r_done  <= 1'b0;
                    r_state <= SR_DUMP_IDLE;
                end
                default: r_state <= SR_DUMP_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sr_regfile_dumper.sv
// tb/tb_sr_regfile_dumper.sv - self-checking bench for sr_regfile_dumper
module tb_sr_regfile_dumper;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        tx_ready;
    logic [2:0]  start_v;
    logic [2:0]  busy_v, done_v, valid_v;
    logic [23:0] data_v;
    logic [14:0] addr_v;
    logic [31:0] regs [32];

    int checks = 0;
    int errors = 0;
    int sel = 0;
    logic [7:0] got [$];

    always #5 clk = ~clk;

    // u0: defaults, u1: single register 5, u2: no headers
    sr_regfile_dumper u0 (
        .clk(clk), .rst_n(rst_n), .start(start_v[0]), .busy(busy_v[0]), .done(done_v[0]),
        .regAddr(addr_v[4:0]), .regData(regs[addr_v[4:0]]),
        .tx_data(data_v[7:0]), .tx_valid(valid_v[0]), .tx_ready(tx_ready));

    sr_regfile_dumper #(.FIRST_REG(5), .LAST_REG(5)) u1 (
        .clk(clk), .rst_n(rst_n), .start(start_v[1]), .busy(busy_v[1]), .done(done_v[1]),
        .regAddr(addr_v[9:5]), .regData(regs[addr_v[9:5]]),
        .tx_data(data_v[15:8]), .tx_valid(valid_v[1]), .tx_ready(tx_ready));

    sr_regfile_dumper #(.ADD_HEADER(0)) u2 (
        .clk(clk), .rst_n(rst_n), .start(start_v[2]), .busy(busy_v[2]), .done(done_v[2]),
        .regAddr(addr_v[14:10]), .regData(regs[addr_v[14:10]]),
        .tx_data(data_v[23:16]), .tx_valid(valid_v[2]), .tx_ready(tx_ready));

    logic [7:0] cur_data;
    logic [4:0] cur_addr;
    assign cur_data = data_v[sel*8 +: 8];
    assign cur_addr = addr_v[sel*5 +: 5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // start_mode: 0 pulse, 1 pulse + re-pulse while busy, 2 hold high, 3 already started
    // ready_mode: 0 always ready, 1 ten-cycle stall after two bytes, 2 random
    task automatic run_frame(input int s, input int start_mode, input int ready_mode,
                             input int exp_len);
        int cyc = 0;
        int stall_left = 10;
        bit fin = 0;
        bit stalled = 0;
        logic [7:0] held = 8'h00;
        logic [7:0] sum = 8'h00;
        sel = s;
        got.delete();
        if (start_mode != 3) begin
            @(negedge clk);
            start_v[s] = 1'b1;
            @(negedge clk);
            if (start_mode != 2) start_v[s] = 1'b0;
            chk("busy_rise", 32'(busy_v[s]), 32'd1);
        end
        while (!fin && cyc < 5000) begin
            tx_ready = 1'b1;
            if (ready_mode == 1 && got.size() == 2 && stall_left > 0) begin
                tx_ready = 1'b0;
                stall_left--;
            end else if (ready_mode == 2) begin
                tx_ready = 1'($urandom_range(0, 1));
            end
            if (start_mode == 1) start_v[s] = (cyc == 20 || cyc == 21);
            if (stalled) begin
                checks++;
                if (!valid_v[s] || cur_data !== held) begin
                    errors++;
                    $display("FAIL stall_hold: valid %0b data %0h expected 1 %0h",
                             valid_v[s], cur_data, held);
                end
            end
            if (valid_v[s] && tx_ready) got.push_back(cur_data);
            // Overwrite the CPU value once captured; the snapshot must win
            if (s == 1 && got.size() == 1) regs[5] = 32'hDEAD_BEEF;
            stalled = valid_v[s] && !tx_ready;
            held    = cur_data;
            if (done_v[s]) fin = 1;
            else begin
                @(negedge clk);
                cyc++;
            end
        end
        chk("frame_done_seen", 32'(fin), 32'd1);
        chk("frame_len", 32'(got.size()), 32'(exp_len));
        if (got.size() > 1) begin
            for (int i = 0; i < got.size() - 1; i++) sum += got[i];
            chk("frame_csum", 32'(got[got.size()-1]), 32'(sum));
        end
        chk("busy_fall", 32'(busy_v[s]), 32'd0);
        @(negedge clk);
        chk("done_one_cycle", 32'(done_v[s]), 32'd0);
    endtask

    typedef struct {
        logic [31:0] word;
        int          ready_mode;
        logic [47:0] exp;   // six bytes, first transmitted in [47:40]
    } vec_t;

    vec_t vecs [6];
    logic [47:0] gotv;

    initial begin
        rst_n    = 1'b0;
        start_v  = 3'b000;
        tx_ready = 1'b0;
        for (int i = 0; i < 32; i++) regs[i] = 32'h0;

        vecs[0] = '{32'h1234_5678, 0, 48'hA5_78_56_34_12_B9};
        vecs[1] = '{32'h1234_5678, 1, 48'hA5_78_56_34_12_B9};
        vecs[2] = '{32'h0000_0000, 0, 48'hA5_00_00_00_00_A5};
        vecs[3] = '{32'hFFFF_FFFF, 2, 48'hA5_FF_FF_FF_FF_A1};
        vecs[4] = '{32'h0102_0304, 0, 48'hA5_04_03_02_01_AF};
        vecs[5] = '{32'h8000_0001, 2, 48'hA5_01_00_00_80_26};

        repeat (3) @(negedge clk);
        chk("rst_busy",  32'(busy_v),  32'd0);
        chk("rst_done",  32'(done_v),  32'd0);
        chk("rst_valid", 32'(valid_v), 32'd0);
        chk("rst_data",  32'(data_v),  32'd0);
        chk("rst_addr0", 32'(addr_v[4:0]), 32'd0);
        chk("rst_addr1", 32'(addr_v[9:5]), 32'd5);
        rst_n = 1'b1;
        @(negedge clk);

        // Test 1: default range, all zero
        run_frame(0, 0, 0, 161);
        begin
            int bad = 0;
            for (int k = 0; k < 32; k++) begin
                if (got[5*k] !== 8'(8'hA0 + k)) bad++;
                for (int j = 1; j < 5; j++) if (got[5*k+j] !== 8'h00) bad++;
            end
            chk("t1_layout_bad_bytes", 32'(bad), 32'd0);
            chk("t1_csum", 32'(got[160]), 32'hF0);
        end

        // Tests 2/3: single register vectors, including stall and random backpressure
        for (int v = 0; v < 6; v++) begin
            regs[5] = vecs[v].word;
            run_frame(1, 0, vecs[v].ready_mode, 6);
            gotv = 48'h0;
            for (int i = 0; i < 6 && i < got.size(); i++) gotv[(5-i)*8 +: 8] = got[i];
            chk($sformatf("vec%0d_bytes", v), 32'(gotv[47:24]), 32'(vecs[v].exp[47:24]));
            chk($sformatf("vec%0d_tail", v), 32'(gotv[23:0]), 32'(vecs[v].exp[23:0]));
        end

        // Test 4: no headers, reg i holds byte i in every lane
        for (int i = 0; i < 32; i++) regs[i] = {4{8'(i)}};
        run_frame(2, 0, 0, 129);
        begin
            int bad = 0;
            for (int k = 0; k < 32; k++)
                for (int j = 0; j < 4; j++) if (got[4*k+j] !== 8'(k)) bad++;
            chk("t4_data_bad_bytes", 32'(bad), 32'd0);
            chk("t4_csum", 32'(got[128]), 32'hC0);
        end
        for (int i = 0; i < 32; i++) regs[i] = 32'h0;

        // Test 5: re-pulse ignored; held start chains a second frame
        run_frame(0, 1, 0, 161);
        run_frame(0, 2, 0, 161);
        chk("t5_gap_idle", 32'(busy_v[0]), 32'd0);
        @(negedge clk);
        chk("t5_restart_busy", 32'(busy_v[0]), 32'd1);
        start_v[0] = 1'b0;
        run_frame(0, 3, 0, 161);
        chk("t5_second_hdr", 32'(got[0]), 32'hA0);

        // Test 6: reset while sending register 10
        sel = 0;
        tx_ready = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        begin
            int cyc = 0;
            while (!(cur_addr == 5'd10 && valid_v[0]) && cyc < 500) begin
                @(negedge clk);
                cyc++;
            end
            chk("t6_reached_reg10", 32'(cyc < 500), 32'd1);
        end
        rst_n = 1'b0;
        #1;
        chk("t6_busy",  32'(busy_v[0]),  32'd0);
        chk("t6_valid", 32'(valid_v[0]), 32'd0);
        chk("t6_data",  32'(data_v[7:0]), 32'd0);
        chk("t6_addr",  32'(addr_v[4:0]), 32'd0);
        chk("t6_done",  32'(done_v[0]),  32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        run_frame(0, 0, 0, 161);
        chk("t6_first_hdr", 32'(got[0]), 32'hA0);
        chk("t6_csum", 32'(got[160]), 32'hF0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
